// File: rtl/rst_seq.sv
// Reset sequencer for the sysclk domain. It waits for a stable PLL lock,
// holds the Ethernet PHY in hardware reset for a minimum time, lets the PHY
// settle, and then releases the system reset. Loss of lock or a soft-reset
// request re-runs the sequence.
module rst_seq #(
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int PHY_RST_CYCLES     = 1250000,
  parameter int PHY_SETTLE_CYCLES  = 6250000,
  parameter int CNT_W              = 24
) (
  input  logic       sysclk,
  input  logic       rst_n,
  input  logic       clk_locked,
  input  logic       soft_rst,
  output logic       phy_rst_n,
  output logic       sys_rst_n,
  output logic       ready,
  output logic [7:0] rst_count
);

  // Terminal counts, compared at the counter width.
  localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] PHY_LAST    = CNT_W'(PHY_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(PHY_SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  typedef enum logic [2:0] {
    WAIT_LOCK   = 3'd0,
    LOCK_STABLE = 3'd1,
    PHY_RST     = 3'd2,
    PHY_SETTLE  = 3'd3,
    RUN         = 3'd4
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             enter_phy_rst;
  logic [7:0]       rst_count_nxt;
  logic             phy_rst_n_nxt;
  logic             sys_rst_n_nxt;
  logic             rst_meta;

  // First synchroniser stage: clears asynchronously with rst_n and goes high
  // on the first sysclk edge after release. The FSM registers below sample it
  // as the second stage, so the FSM's first live edge is the 2nd edge after
  // rst_n rises while assertion still reaches every register with no clock.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      rst_meta <= 1'b0;
    end else begin
      rst_meta <= 1'b1;
    end
  end

  // Next-state, counter and reset-count decode; lock loss outranks soft reset.
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    enter_phy_rst = 1'b0;

    if (state != WAIT_LOCK && !clk_locked) begin
      state_nxt = WAIT_LOCK;
      cnt_nxt   = '0;
    end else if (soft_rst &&
                 (state == PHY_RST || state == PHY_SETTLE || state == RUN)) begin
      // Entry or restart of PHY_RST; a held request restarts every cycle.
      state_nxt     = PHY_RST;
      cnt_nxt       = '0;
      enter_phy_rst = 1'b1;
    end else begin
      unique case (state)
        WAIT_LOCK: begin
          cnt_nxt = '0;
          if (clk_locked) begin
            state_nxt = LOCK_STABLE;
          end
        end
        LOCK_STABLE: begin
          if (cnt == LOCK_LAST) begin
            state_nxt     = PHY_RST;
            cnt_nxt       = '0;
            enter_phy_rst = 1'b1;
          end else begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end
        PHY_RST: begin
          if (cnt == PHY_LAST) begin
            state_nxt = PHY_SETTLE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end
        PHY_SETTLE: begin
          if (cnt == SETTLE_LAST) begin
            state_nxt = RUN;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end
        RUN: begin
          cnt_nxt = '0;
        end
        default: begin
          state_nxt = WAIT_LOCK;
          cnt_nxt   = '0;
        end
      endcase
    end

    // Saturating count of PHY reset entries and restarts.
    rst_count_nxt = rst_count;
    if (enter_phy_rst && rst_count != 8'hFF) begin
      rst_count_nxt = rst_count + 8'd1;
    end

    // Reset outputs are decoded from the next state so they move with it.
    phy_rst_n_nxt = (state_nxt == PHY_SETTLE) || (state_nxt == RUN);
    sys_rst_n_nxt = (state_nxt == RUN);
  end

  // State, counter and registered outputs; held at reset values until the
  // synchroniser first stage has released.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= WAIT_LOCK;
      cnt       <= '0;
      phy_rst_n <= 1'b0;
      sys_rst_n <= 1'b0;
      rst_count <= 8'd0;
    end else if (!rst_meta) begin
      state     <= WAIT_LOCK;
      cnt       <= '0;
      phy_rst_n <= 1'b0;
      sys_rst_n <= 1'b0;
      rst_count <= 8'd0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      phy_rst_n <= phy_rst_n_nxt;
      sys_rst_n <= sys_rst_n_nxt;
      rst_count <= rst_count_nxt;
    end
  end

  assign ready = sys_rst_n;

endmodule

// File: tb/tb_rst_seq.sv
// Randomised and directed bench for rst_seq. A reference model kept in terms
// of "edge at which lock sequencing began" and "edge at which the PHY reset
// was last entered" predicts the outputs after every edge; a monitor on the
// falling edge compares them against the DUT.
module tb_rst_seq;

  localparam int L = 4;
  localparam int R = 8;
  localparam int S = 6;

  logic       sysclk = 1'b0;
  logic       rst_n;
  logic       clk_locked;
  logic       soft_rst;
  logic       phy_rst_n;
  logic       sys_rst_n;
  logic       ready;
  logic [7:0] rst_count;

  rst_seq #(
    .LOCK_STABLE_CYCLES(L),
    .PHY_RST_CYCLES    (R),
    .PHY_SETTLE_CYCLES (S),
    .CNT_W             (8)
  ) dut (
    .sysclk    (sysclk),
    .rst_n     (rst_n),
    .clk_locked(clk_locked),
    .soft_rst  (soft_rst),
    .phy_rst_n (phy_rst_n),
    .sys_rst_n (sys_rst_n),
    .ready     (ready),
    .rst_count (rst_count)
  );

  always #5 sysclk = ~sysclk;

  typedef struct packed {
    logic       phy;
    logic       sys;
    logic [7:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  // Reference model state.
  int n_edge     = 0;
  int rel        = 0;   // edges seen since rst_n released
  int lock_start = -1;  // edge where lock sequencing began, -1 while waiting
  int phy_start  = -1;  // edge of latest PHY reset entry, -1 if none yet
  int m_count    = 0;

  function automatic void model_clear();
    rel        = 0;
    lock_start = -1;
    phy_start  = -1;
    m_count    = 0;
  endfunction

  function automatic void bump();
    if (m_count < 255) m_count = m_count + 1;
  endfunction

  function automatic void model_edge(input bit lck, input bit sft, input bit rstv);
    n_edge = n_edge + 1;
    if (!rstv) begin
      model_clear();
      return;
    end
    rel = rel + 1;
    if (rel < 2) return;
    if (lock_start >= 0 && !lck) begin
      lock_start = -1;
      phy_start  = -1;
    end else if (lock_start < 0) begin
      if (lck) lock_start = n_edge;
    end else if (phy_start >= 0 && sft) begin
      phy_start = n_edge;
      bump();
    end else if (phy_start < 0 && (n_edge - lock_start) == L) begin
      phy_start = n_edge;
      bump();
    end
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    int   d;
    e.cnt = 8'(m_count);
    if (phy_start < 0) begin
      e.phy = 1'b0;
      e.sys = 1'b0;
    end else begin
      d     = n_edge - phy_start;
      e.phy = (d >= R);
      e.sys = (d >= R + S);
    end
    return e;
  endfunction

  // One clock: drive inputs, let the edge happen, update the model, and
  // optionally drop rst_n between edges before publishing the expectation.
  task automatic step(input bit lck, input bit sft, input bit rstv, input bit mid_drop);
    clk_locked = lck;
    soft_rst   = sft;
    rst_n      = rstv;
    if (!rstv) model_clear();
    @(posedge sysclk);
    model_edge(lck, sft, rstv);
    #2;
    if (mid_drop) begin
      rst_n = 1'b0;
      model_clear();
    end
    #1;
    exp_q.push_back(model_out());
  endtask

  // Monitor: compare DUT outputs with the oldest expectation mid-cycle.
  always @(negedge sysclk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e       = exp_q.pop_front();
      vectors = vectors + 1;
      if (phy_rst_n !== e.phy || sys_rst_n !== e.sys || ready !== e.sys ||
          rst_count !== e.cnt) begin
        miscompares = miscompares + 1;
        $display("FAIL outputs vec%0d t=%0t: got phy_rst_n=%b sys_rst_n=%b ready=%b rst_count=%0d, want phy_rst_n=%b sys_rst_n=%b ready=%b rst_count=%0d",
                 vectors, $time, phy_rst_n, sys_rst_n, ready, rst_count,
                 e.phy, e.sys, e.sys, e.cnt);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not finish, %0d vectors applied", vectors);
    $fatal(1);
  end

  initial begin
    int low;
    bit lck, sft, mid;

    rst_n      = 1'b1;
    clk_locked = 1'b1;
    soft_rst   = 1'b0;
    model_clear();
    #1 rst_n = 1'b0;
    #1;
    vectors = vectors + 1;
    if (phy_rst_n !== 1'b0 || sys_rst_n !== 1'b0 || ready !== 1'b0 || rst_count !== 8'd0) begin
      miscompares = miscompares + 1;
      $display("FAIL reset_state: got phy_rst_n=%b sys_rst_n=%b ready=%b rst_count=%0d, want 0 0 0 0",
               phy_rst_n, sys_rst_n, ready, rst_count);
    end

    // Power-up: lock already high, release rst_n and run to RUN.
    repeat (3) step(1, 0, 0, 0);
    repeat (24) step(1, 0, 1, 0);

    // Lock loss in RUN, then a one-cycle dropout early in LOCK_STABLE.
    step(0, 0, 1, 0);
    repeat (3) step(1, 0, 1, 0);
    step(0, 0, 1, 0);
    repeat (25) step(1, 0, 1, 0);

    // Single soft-reset pulse in RUN.
    step(1, 1, 1, 0);
    repeat (20) step(1, 0, 1, 0);

    // Soft reset held for 20 cycles while in PHY_RST.
    step(1, 1, 1, 0);
    repeat (2) step(1, 0, 1, 0);
    repeat (20) step(1, 1, 1, 0);
    repeat (35) step(1, 0, 1, 0);

    // Asynchronous rst_n assertion in the middle of PHY_SETTLE.
    step(1, 1, 1, 0);
    repeat (9) step(1, 0, 1, 0);
    step(1, 0, 1, 1);
    repeat (2) step(1, 0, 0, 0);
    repeat (24) step(1, 0, 1, 0);

    // 300 soft-reset pulses drive rst_count into saturation.
    for (int i = 0; i < 300; i++) begin
      step(1, 1, 1, 0);
      step(1, 0, 1, 0);
    end
    repeat (20) step(1, 0, 1, 0);

    // Random mix of lock dropouts, soft resets and asynchronous resets.
    low = 0;
    for (int i = 0; i < 600; i++) begin
      lck = ($urandom_range(31) != 0);
      sft = ($urandom_range(7) == 0);
      mid = (low == 0) && ($urandom_range(249) == 0);
      step(lck, sft, (low == 0), mid);
      if (mid) low = 1 + $urandom_range(2);
      else if (low > 0) low = low - 1;
    end
    repeat (22) step(1, 0, 1, 0);

    @(negedge sysclk);
    #1;
    vectors = vectors + 1;
    if (exp_q.size() != 0) begin
      miscompares = miscompares + 1;
      $display("FAIL drain: got %0d expectations left, want 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
